body_code_tx: RTL

- Transmitter end of the body-code link; the receive side recovers the 3-bit body code and classifies it.
- Accepts a parallel 3-bit body code over a valid/ready handshake.
- Sends it on one serial line as a framed word: start bit, data bits LSB-first, even-parity bit, stop bit.
- Each bit is held for a fixed number of clock cycles.

---
 rtl/body_code_tx.sv | 103 ++++++++++
 1 files changed

// File: rtl/body_code_tx.sv
// body_code_tx: serial transmitter for the body code.
// Each frame is a start bit, the data bits LSB-first, an even-parity bit and a stop bit.
module body_code_tx #(
  parameter int CODE_W     = 3,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int TW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = CODE_W > 1 ? $clog2(CODE_W) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [CODE_W-1:0] sh_q, sh_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] idx_q, idx_d;
  logic par_q, par_d, tx_q, tx_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic wrap;
  assign wrap = timer_q == TW'(BIT_CYCLES - 1);
  // The shift register moves right as bits go out, so the next data bit is always sh_q[0]
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    par_d   = par_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    timer_d = (state_q == IDLE || wrap) ? '0 : timer_q + TW'(1);
    case (state_q)
      IDLE: if (code_valid && ready_q) begin
        state_d = START;
        sh_d    = code;
        par_d   = ^code;
        idx_d   = '0;
        timer_d = '0;
        tx_d    = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
      end
      START: if (wrap) begin
        state_d = DATA;
        tx_d    = sh_q[0];
        sh_d    = sh_q >> 1;
      end
      DATA: if (wrap) begin
        if (idx_q == IW'(CODE_W - 1)) begin
          state_d = PARITY;
          tx_d    = par_q;
        end else begin
          idx_d = idx_q + IW'(1);
          tx_d  = sh_q[0];
          sh_d  = sh_q >> 1;
        end
      end
      PARITY: if (wrap) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (wrap) begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      timer_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign tx         = tx_q;
  assign code_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule
